// File: rtl/rgmii_ddr_tx_gear_pkg.sv
// Shared constants and helpers for the RGMII DDR transmit gearbox.
package rgmii_ddr_tx_gear_pkg;

  // Speed codes as presented on the speed / active_speed ports.
  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;

  // MAC cycles per forwarded clock period at the slow speeds.
  localparam int DEFAULT_DIV_100 = 5;
  localparam int DEFAULT_DIV_10  = 50;

  // Which nibble of the current byte is being driven at 10/100.
  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } nib_phase_e;

  // Both 2'b10 and 2'b11 select gigabit operation.
  function automatic logic is_gig(input logic [1:0] s);
    return s[1];
  endfunction

  // Fold the reserved code 2'b11 onto 1G so active_speed only shows real modes.
  function automatic logic [1:0] norm_speed(input logic [1:0] s);
    return s[1] ? SPEED_1000 : s;
  endfunction

endpackage

// File: rtl/rgmii_ddr_tx_gear_ddr_clk_pattern_gen.sv
// Period counter and forwarded-clock pattern generator.
// Produces registered rising/falling halves of a clock whose period is
// `div` MAC cycles: a half is high when its half-cycle index is below div.
module ddr_clk_pattern_gen #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] div,      // divider that applies from the next cycle on
  input  logic             restart,  // force the counter back to 0 next cycle
  output logic             cnt_last, // counter is at div-1 this cycle
  output logic             clk_q1,
  output logic             clk_q2
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q;
  logic             clk_q1_q, clk_q1_d;
  logic             clk_q2_q, clk_q2_d;
  logic [CNT_W:0]   idx_rise, idx_fall, div_ext;

  // The divider in effect this cycle is the one registered last cycle.
  assign cnt_last = (cnt_q == (div_q - CNT_W'(1)));

  // Next count and the clock halves belonging to that next count, so the
  // registered pattern lines up with the counter value it describes.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || cnt_last) begin
      cnt_d = '0;
    end
    idx_rise = {cnt_d, 1'b0};
    idx_fall = {cnt_d, 1'b1};
    div_ext  = {1'b0, div};
    clk_q1_d = (idx_rise < div_ext);
    clk_q2_d = (idx_fall < div_ext);
  end

  // Counter, divider and pattern registers; reset parks in the 1G setting.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      div_q    <= CNT_W'(1);
      clk_q1_q <= 1'b0;
      clk_q2_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div;
      clk_q1_q <= clk_q1_d;
      clk_q2_q <= clk_q2_d;
    end
  end

  assign clk_q1 = clk_q1_q;
  assign clk_q2 = clk_q2_q;

endmodule

// File: rtl/rgmii_ddr_tx_gear.sv
// RGMII transmit gearbox: byte handshake in, per-cycle DDR half pairs out.
// At 1G each accepted byte is sent in one cycle (low nibble on the rising
// half). At 10/100 each byte occupies 2*N cycles, the low nibble repeated on
// both halves for N cycles, then the high nibble for N cycles.
module rgmii_ddr_tx_gear
  import rgmii_ddr_tx_gear_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DIV_100 = DEFAULT_DIV_100,
  parameter int DIV_10  = DEFAULT_DIV_10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         speed,
  input  logic [2*WIDTH-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_clk_q1,
  output logic               out_clk_q2,
  output logic [WIDTH-1:0]   out_q1,
  output logic [WIDTH-1:0]   out_q2,
  output logic [1:0]         active_speed
);

  localparam int MAX_DIV = (DIV_10 > DIV_100) ? DIV_10 : DIV_100;
  localparam int CNT_W   = $clog2(MAX_DIV + 1);

  localparam logic [CNT_W-1:0] DIV_1000_C = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_100_C  = CNT_W'(DIV_100);
  localparam logic [CNT_W-1:0] DIV_10_C   = CNT_W'(DIV_10);

  logic [1:0]       active_speed_q, active_speed_d;
  nib_phase_e       ph_q, ph_d;
  logic [WIDTH-1:0] hi_nib_q, hi_nib_d;
  logic [WIDTH-1:0] out_q1_q, out_q1_d;
  logic [WIDTH-1:0] out_q2_q, out_q2_d;

  logic             boundary;
  logic             accept;
  logic             restart;
  logic             cnt_last;
  logic             gig_next;
  logic [CNT_W-1:0] div_next;
  logic [WIDTH-1:0] lo_in, hi_in;

  assign lo_in = in_data[WIDTH-1:0];
  assign hi_in = in_data[2*WIDTH-1:WIDTH];

  // Byte boundary, handshake and speed latch; speed only moves between bytes.
  always_comb begin
    boundary       = is_gig(active_speed_q) || (cnt_last && (ph_q == PH_HIGH));
    in_ready       = boundary && !rst;
    accept         = in_valid && in_ready;
    active_speed_d = active_speed_q;
    if (boundary) begin
      active_speed_d = norm_speed(speed);
    end
    gig_next = is_gig(active_speed_d);
    restart  = boundary && (active_speed_d != active_speed_q);
    case (active_speed_d)
      SPEED_100: div_next = DIV_100_C;
      SPEED_10:  div_next = DIV_10_C;
      default:   div_next = DIV_1000_C;
    endcase
  end

  // Nibble phase flips at the end of each forwarded-clock period at 10/100
  // and is pinned low at 1G or when a new speed takes over.
  always_comb begin
    ph_d = ph_q;
    if (gig_next || restart) begin
      ph_d = PH_LOW;
    end else if (cnt_last) begin
      ph_d = (ph_q == PH_LOW) ? PH_HIGH : PH_LOW;
    end
  end

  // Data path: load a new byte (or zeros) at a boundary, formatted for the
  // speed that will be in effect; at 10/100 swap to the stored high nibble
  // halfway through the byte slot.
  always_comb begin
    out_q1_d = out_q1_q;
    out_q2_d = out_q2_q;
    hi_nib_d = hi_nib_q;
    if (boundary) begin
      if (gig_next) begin
        out_q1_d = accept ? lo_in : '0;
        out_q2_d = accept ? hi_in : '0;
        hi_nib_d = '0;
      end else begin
        out_q1_d = accept ? lo_in : '0;
        out_q2_d = accept ? lo_in : '0;
        hi_nib_d = accept ? hi_in : '0;
      end
    end else if (cnt_last && (ph_q == PH_LOW)) begin
      out_q1_d = hi_nib_q;
      out_q2_d = hi_nib_q;
    end
  end

  // State and output registers; reset aborts any byte in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_speed_q <= SPEED_1000;
      ph_q           <= PH_LOW;
      hi_nib_q       <= '0;
      out_q1_q       <= '0;
      out_q2_q       <= '0;
    end else begin
      active_speed_q <= active_speed_d;
      ph_q           <= ph_d;
      hi_nib_q       <= hi_nib_d;
      out_q1_q       <= out_q1_d;
      out_q2_q       <= out_q2_d;
    end
  end

  ddr_clk_pattern_gen #(
    .CNT_W (CNT_W)
  ) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .div      (div_next),
    .restart  (restart),
    .cnt_last (cnt_last),
    .clk_q1   (out_clk_q1),
    .clk_q2   (out_clk_q2)
  );

  assign out_q1       = out_q1_q;
  assign out_q2       = out_q2_q;
  assign active_speed = active_speed_q;

endmodule

// File: tb/tb_rgmii_ddr_tx_gear.sv
// Self-checking bench for rgmii_ddr_tx_gear: table vectors, directed
// multi-cycle sequences and a per-cycle scoreboard of expected outputs.
`timescale 1ns/1ps
module tb_rgmii_ddr_tx_gear;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] speed = 2'b10;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       out_clk_q1, out_clk_q2;
  logic [3:0] out_q1, out_q2;
  logic [1:0] active_speed;

  always #4 clk = ~clk;

  rgmii_ddr_tx_gear #(
    .WIDTH   (4),
    .DIV_100 (5),
    .DIV_10  (50)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .speed        (speed),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_clk_q1   (out_clk_q1),
    .out_clk_q2   (out_clk_q2),
    .out_q1       (out_q1),
    .out_q2       (out_q2),
    .active_speed (active_speed)
  );

  typedef struct packed {
    logic       c1;
    logic       c2;
    logic [3:0] q1;
    logic [3:0] q2;
    logic [1:0] spd;
  } obs_t;

  typedef struct {
    logic       rst;
    logic [1:0] spd;
    logic       vld;
    logic [7:0] d;
    logic       exp_rdy;
    logic [3:0] eq1;
    logic [3:0] eq2;
    logic       ec1;
    logic       ec2;
  } vec_t;

  obs_t sb[$];
  obs_t last_obs;
  logic last_ready;
  int   passed = 0;
  int   total = 0;
  int   accepted = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int div_of(input logic [1:0] s);
    if (s == 2'b01) return 5;
    if (s == 2'b00) return 50;
    return 1;
  endfunction

  // Expected output stream for one byte slot starting on the next cycle.
  task automatic push_slot(input logic [1:0] spd, input logic acc, input logic [7:0] d);
    int   n;
    int   len;
    int   c;
    obs_t e;
    n   = div_of(spd);
    len = (n == 1) ? 1 : 2 * n;
    for (int k = 0; k < len; k++) begin
      c    = k % n;
      e.c1 = (2 * c < n);
      e.c2 = (2 * c + 1 < n);
      if (n == 1) begin
        e.q1 = acc ? d[3:0] : 4'h0;
        e.q2 = acc ? d[7:4] : 4'h0;
      end else begin
        e.q1 = acc ? ((k < n) ? d[3:0] : d[7:4]) : 4'h0;
        e.q2 = e.q1;
      end
      e.spd = spd[1] ? 2'b10 : spd;
      sb.push_back(e);
    end
  endtask

  // One MAC cycle: drive inputs at a negedge, check in_ready, then check the
  // outputs that follow the next rising edge.
  task automatic step(input logic rst_v, input logic [1:0] spd_v, input logic vld_v,
                      input logic [7:0] d_v);
    logic exp_bnd;
    obs_t obs;
    obs_t e;
    rst      = rst_v;
    speed    = spd_v;
    in_valid = vld_v;
    in_data  = d_v;
    #1;
    exp_bnd    = !rst_v && (sb.size() == 0);
    last_ready = in_ready;
    chk("in_ready", 32'(in_ready), 32'(exp_bnd));
    if (exp_bnd) begin
      push_slot(spd_v, vld_v, d_v);
      if (vld_v) accepted++;
    end
    @(negedge clk);
    obs = {out_clk_q1, out_clk_q2, out_q1, out_q2, active_speed};
    if (rst_v) begin
      sb.delete();
      chk("reset_out", 32'(obs), 32'({2'b00, 8'h00, 2'b10}));
    end else if (sb.size() == 0) begin
      chk("sb_underflow", 32'(1), 32'(0));
    end else begin
      e = sb.pop_front();
      chk("out", 32'(obs), 32'(e));
    end
    last_obs = obs;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   pat1[5];
    int   pat2[5];
    int   cnt;
    int   ones1;
    int   ones2;
    int   nz;
    logic found;
    logic [1:0] rspd;

    tbl[0] = '{1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 2'b10, 1'b1, 8'hFF, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 2'b10, 1'b1, 8'hA5, 1'b1, 4'h5, 4'hA, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 2'b10, 1'b1, 8'h3C, 1'b1, 4'hC, 4'h3, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 2'b10, 1'b0, 8'h99, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 2'b10, 1'b1, 8'hF0, 1'b1, 4'h0, 4'hF, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 2'b11, 1'b1, 8'h00, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 2'b10, 1'b1, 8'h81, 1'b1, 4'h1, 4'h8, 1'b1, 1'b0};
    pat1 = '{1, 1, 1, 0, 0};
    pat2 = '{1, 1, 0, 0, 0};

    @(negedge clk);

    // Reset and 1G table vectors.
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].rst, tbl[i].spd, tbl[i].vld, tbl[i].d);
      chk("tbl_ready", 32'(last_ready), 32'(tbl[i].exp_rdy));
      chk("tbl_data", 32'({out_q1, out_q2}), 32'({tbl[i].eq1, tbl[i].eq2}));
      chk("tbl_clk", 32'({out_clk_q1, out_clk_q2}), 32'({tbl[i].ec1, tbl[i].ec2}));
    end

    // 100M single byte 0x7E.
    step(1'b0, 2'b01, 1'b1, 8'h7E);
    chk("m100_first_q1", 32'(out_q1), 32'(4'hE));
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        chk("m100_q1", 32'(out_q1), 32'((i < 5) ? 4'hE : 4'h7));
        chk("m100_q2", 32'(out_q2), 32'((i < 5) ? 4'hE : 4'h7));
        chk("m100_clk", 32'({out_clk_q1, out_clk_q2}),
            32'({1'(pat1[i % 5]), 1'(pat2[i % 5])}));
      end
      step(1'b0, 2'b01, 1'b0, 8'($urandom_range(0, 255)));
      if (last_ready) cnt++;
    end
    chk("m100_ready_pulses", 32'(cnt), 32'(1));
    chk("m100_ready_last", 32'(last_ready), 32'(1));

    // Move to 10M while idle (held off until the current byte slot ends).
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 2'b00, 1'b0, 8'h00);
      found = last_ready;
    end
    chk("m10_switch_seen", 32'(found), 32'(1));
    cnt = 0; ones1 = 0; ones2 = 0; nz = 0;
    for (int i = 0; i < 100; i++) begin
      if (out_clk_q1) ones1++;
      if (out_clk_q2) ones2++;
      if (out_q1 != 4'h0 || out_q2 != 4'h0) nz++;
      step(1'b0, 2'b00, 1'b0, 8'h00);
      if (last_ready) cnt++;
    end
    chk("m10_ready_pulses", 32'(cnt), 32'(1));
    chk("m10_clk_q1_high", 32'(ones1), 32'(50));
    chk("m10_clk_q2_high", 32'(ones2), 32'(50));
    chk("m10_data_zero", 32'(nz), 32'(0));

    // Back to 1G, then switch 1G->100M mid-stream and 100M->10M mid-byte.
    found = 1'b0;
    for (int i = 0; i < 120 && !found; i++) begin
      step(1'b0, 2'b10, 1'b0, 8'h00);
      found = last_ready;
    end
    chk("g1_return_seen", 32'(found), 32'(1));
    step(1'b0, 2'b10, 1'b1, 8'h11);
    step(1'b0, 2'b10, 1'b1, 8'h22);
    step(1'b0, 2'b01, 1'b1, 8'h33);
    chk("sw_to_100_now", 32'(last_obs.spd), 32'(2'b01));
    for (int i = 0; i < 4; i++) step(1'b0, 2'b01, 1'b1, 8'h96);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 2'b00, 1'b1, 8'h4B);
      found = last_ready;
      if (!found) chk("sw_hold_100", 32'(last_obs.spd), 32'(2'b01));
    end
    chk("sw_to_10_seen", 32'(found), 32'(1));
    chk("sw_to_10_speed", 32'(last_obs.spd), 32'(2'b00));
    chk("sw_to_10_clk", 32'({out_clk_q1, out_clk_q2}), 32'(2'b11));

    // Reset in the middle of a 100M high nibble.
    found = 1'b0;
    for (int i = 0; i < 120 && !found; i++) begin
      step(1'b0, 2'b01, 1'b1, 8'hC3);
      found = last_ready;
    end
    chk("rst_seq_byte_seen", 32'(found), 32'(1));
    for (int i = 0; i < 6; i++) step(1'b0, 2'b01, 1'b0, 8'h00);
    chk("rst_seq_high_nibble", 32'(out_q1), 32'(4'hC));
    step(1'b1, 2'b01, 1'b0, 8'h00);
    chk("rst_seq_speed", 32'(active_speed), 32'(2'b10));
    step(1'b0, 2'b10, 1'b1, 8'h5A);
    chk("rst_seq_ready", 32'(last_ready), 32'(1));
    chk("rst_seq_data", 32'({out_q1, out_q2}), 32'(8'hA5));

    // Random valid gaps and speed changes against the scoreboard.
    rspd = 2'b10;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 2))
          0:       rspd = 2'b00;
          1:       rspd = 2'b01;
          default: rspd = 2'b10;
        endcase
      end
      step(($urandom_range(0, 599) == 0), rspd, 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)));
    end
    chk("random_bytes_accepted", 32'(accepted > 20), 32'(1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
